stream_queue_bank: RTL and testbench
====================================

STREAM_QUEUE_BANK -- requirements
Module: stream_queue_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, number of independent stream channels (1..32).
REQ-002 SHALL have parameter W, default 9, data width per token, excluding the end-of-stream bit.
REQ-003 SHALL have parameter DEPTH, default 16, slots per channel; power of two, at least 2.
REQ-004 SHALL have parameter RESERVE, default 0, slots kept free after back-pressure asserts (0 <= RESERVE < DEPTH).
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port qin_d, input, NCH*W bits: write data; channel c occupies bits [c*W +: W].
REQ-008 SHALL have port qin_e, input, NCH bits: end-of-stream flag travelling with each token.
REQ-009 SHALL have port qin_v, input, NCH bits: producer token valid.
REQ-010 SHALL have port qin_b, output, NCH bits: back-pressure to the producer.
REQ-011 SHALL have port qout_d, output, NCH*W bits: head-of-queue data, packed as qin_d.
REQ-012 SHALL have port qout_e, output, NCH bits: head-of-queue end-of-stream flag.
REQ-013 SHALL have port qout_v, output, NCH bits: head valid (channel non-empty).
REQ-014 SHALL have port qout_b, input, NCH bits: consumer back-pressure; high means stall.
REQ-015 SHALL have port flush, input, NCH bits: synchronous per-channel empty.
REQ-016 SHALL have port count, output, NCH*CW bits, CW = clog2(DEPTH+1): per-channel occupancy.
REQ-017 SHALL have port ovf, output, NCH bits: sticky per-channel overflow error.

Function
REQ-018 SHALL keep all channels fully independent; no event on channel c affects channel d.
REQ-019 SHALL treat a push on channel c as qin_v[c]=1 at a clock edge; a push is attempted regardless of qin_b[c].
REQ-020 SHALL treat a pop as qout_v[c]=1 and qout_b[c]=0 at a clock edge.
REQ-021 SHALL store each token as {d,e} in a circular buffer of DEPTH entries with wrapping read and write pointers of clog2(DEPTH) bits.
REQ-022 SHALL drive qout_d, qout_e and qout_v combinationally from the head entry and count register (qout_v = count!=0); a token pushed at edge t SHALL appear at qout at t+1 if the channel was empty.
REQ-023 SHALL accept a push when count<DEPTH, or when count==DEPTH with a pop on the same edge.
REQ-024 SHALL update count +1 on a push, -1 on a pop, and leave it unchanged on a simultaneous push and pop; count SHALL never exceed DEPTH or go below 0.
REQ-025 SHALL drop a push arriving at count==DEPTH without a pop, leave the stored contents unchanged, and set ovf[c]=1; ovf[c] SHALL clear only on reset.
REQ-026 SHALL drive qin_b[c] = (count >= DEPTH-RESERVE), decoded from the count register only (no combinational path from qin_v or qout_b).
REQ-027 SHALL, on flush[c]=1, set count, read pointer and write pointer to 0 at that edge; a push or pop on the same edge SHALL be ignored; ovf SHALL be unaffected.
REQ-028 SHALL produce no qout_v glitch on pointer wrap; the DEPTH-1 -> 0 transition SHALL be indistinguishable from other transitions.
REQ-029 SHALL pass qin_e unmodified; the end-of-stream bit SHALL have no effect on queue control.

Reset
REQ-030 SHALL, while reset=1 (asynchronous), force all counts, pointers and ovf to 0, giving qout_v=0, qin_b=0 and count=0 on every channel; storage contents are don't-care.
REQ-031 SHALL discard in-flight tokens when reset asserts mid-operation, and SHALL accept a push on the first edge after reset deasserts.

Verification
REQ-032 SHALL cover: NCH=8, DEPTH=16, RESERVE=0; push 0x0A5 on ch3 with qout_b=0 -> qout_v[3]=1 and qout_d ch3=0x0A5 the next cycle; other channels qout_v=0.
REQ-033 SHALL cover: qout_b[0]=1; push 16 tokens 0..15 on ch0 -> count=16 and qin_b[0]=1; 17th push -> ovf[0]=1; then drain -> 0..15 out in order.
REQ-034 SHALL cover: RESERVE=2, ch1 stalled -> qin_b[1] rises when count reaches 14; 2 further pushes are accepted with ovf[1]=0.
REQ-035 SHALL cover: ch2 full with simultaneous push and pop for 40 cycles -> count stays 16, ovf[2]=0, output sequence continuous across the pointer wrap.
REQ-036 SHALL cover: ch5 holding 7 tokens; flush[5] with a push on the same edge -> next cycle count=0 and qout_v[5]=0; ch4 unaffected.
REQ-037 SHALL cover: asynchronous reset pulse mid-stream, between clock edges -> all outputs reach their reset values immediately; ovf is cleared.

Source files
------------

// File: rtl/stream_queue_bank.sv
// Bank of NCH independent circular-buffer token queues with per-channel flush,
// occupancy count, registered back-pressure threshold and sticky overflow flag.
module stream_queue_bank #(
  parameter int NCH     = 8,
  parameter int W       = 9,
  parameter int DEPTH   = 16,
  parameter int RESERVE = 0,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*W-1:0]  qin_d,
  input  logic [NCH-1:0]    qin_e,
  input  logic [NCH-1:0]    qin_v,
  output logic [NCH-1:0]    qin_b,
  output logic [NCH*W-1:0]  qout_d,
  output logic [NCH-1:0]    qout_e,
  output logic [NCH-1:0]    qout_v,
  input  logic [NCH-1:0]    qout_b,
  input  logic [NCH-1:0]    flush,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR  = CW'(DEPTH - RESERVE);

  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  logic [AW-1:0] rp_q  [NCH];
  logic [AW-1:0] rp_d  [NCH];
  logic [AW-1:0] wp_q  [NCH];
  logic [AW-1:0] wp_d  [NCH];
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] pop, push, wr_en;
  logic [W:0]     wr_data [NCH];

  always_comb begin
    cnt_d = cnt_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    ovf_d = ovf_q;
    for (int c = 0; c < NCH; c++) begin
      pop[c]     = (cnt_q[c] != '0) && !qout_b[c];
      // A full queue still accepts when the head leaves on the same edge.
      push[c]    = qin_v[c] && ((cnt_q[c] != FULL) || pop[c]);
      wr_en[c]   = push[c] && !flush[c];
      wr_data[c] = {qin_d[c*W +: W], qin_e[c]};
      if (flush[c]) begin
        cnt_d[c] = '0;
        rp_d[c]  = '0;
        wp_d[c]  = '0;
      end else begin
        if (push[c]) wp_d[c] = wp_q[c] + AW'(1);
        if (pop[c])  rp_d[c] = rp_q[c] + AW'(1);
        if (push[c] && !pop[c])      cnt_d[c] = cnt_q[c] + CW'(1);
        else if (pop[c] && !push[c]) cnt_d[c] = cnt_q[c] - CW'(1);
        if (qin_v[c] && !push[c])    ovf_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
      rp_q  <= '{default: '0};
      wp_q  <= '{default: '0};
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // Token storage is data only: no reset, contents are don't-care when empty.
    logic [W:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en[g]) mem_q[wp_q[g]] <= wr_data[g];
    end

    assign qout_d[g*W +: W]   = mem_q[rp_q[g]][W:1];
    assign qout_e[g]          = mem_q[rp_q[g]][0];
    assign qout_v[g]          = (cnt_q[g] != '0);
    assign qin_b[g]           = (cnt_q[g] >= THR);
    assign count[g*CW +: CW]  = cnt_q[g];
  end

endmodule

// File: tb/tb_stream_queue_bank.sv
// Self-checking bench for stream_queue_bank: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the channel bank.
module tb_stream_queue_bank;
  localparam int NCH = 8, W = 9, DEPTH = 16, CW = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH*W-1:0]  qin_d;
  logic [NCH-1:0]    qin_e, qin_v, qout_b, flush;
  logic [NCH-1:0]    qin_b0, qout_e0, qout_v0, ovf0;
  logic [NCH-1:0]    qin_b2, qout_e2, qout_v2, ovf2;
  logic [NCH*W-1:0]  qout_d0, qout_d2;
  logic [NCH*CW-1:0] count0, count2;

  int total = 0;
  int bad = 0;

  logic [W:0]     mq [NCH][$];
  logic [NCH-1:0] movf;

  always #5 clock = ~clock;

  stream_queue_bank #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .RESERVE(0)) u_r0 (
    .clock(clock), .reset(reset), .qin_d(qin_d), .qin_e(qin_e), .qin_v(qin_v),
    .qin_b(qin_b0), .qout_d(qout_d0), .qout_e(qout_e0), .qout_v(qout_v0),
    .qout_b(qout_b), .flush(flush), .count(count0), .ovf(ovf0));

  stream_queue_bank #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .RESERVE(2)) u_r2 (
    .clock(clock), .reset(reset), .qin_d(qin_d), .qin_e(qin_e), .qin_v(qin_v),
    .qin_b(qin_b2), .qout_d(qout_d2), .qout_e(qout_e2), .qout_v(qout_v2),
    .qout_b(qout_b), .flush(flush), .count(count2), .ovf(ovf2));

  function automatic logic [CW-1:0] cnt0(int c); return count0[c*CW +: CW]; endfunction
  function automatic logic [CW-1:0] cnt2(int c); return count2[c*CW +: CW]; endfunction
  function automatic logic [W-1:0]  dat0(int c); return qout_d0[c*W +: W]; endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    movf = '0;
  endtask

  // One clock edge: the model applies the queue rules to the inputs seen at the edge.
  task automatic tick();
    @(posedge clock);
    for (int c = 0; c < NCH; c++) begin
      if (flush[c]) mq[c].delete();
      else begin
        bit full, popped;
        full   = (mq[c].size() == DEPTH);
        popped = (mq[c].size() != 0) && !qout_b[c];
        if (popped) void'(mq[c].pop_front());
        if (qin_v[c]) begin
          if (!full || popped) mq[c].push_back({qin_d[c*W +: W], qin_e[c]});
          else movf[c] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    qin_d = '0; qin_e = '0; qin_v = '0; qout_b = '0; flush = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    total++; if (qout_v0 !== '0) begin bad++; $display("FAIL reset_qout_v got=%h want=0", qout_v0); end
    total++; if (qin_b0 !== '0 || qin_b2 !== '0) begin bad++; $display("FAIL reset_qin_b got=%h/%h want=0", qin_b0, qin_b2); end
    total++; if (count0 !== '0) begin bad++; $display("FAIL reset_count got=%h want=0", count0); end
    total++; if (ovf0 !== '0) begin bad++; $display("FAIL reset_ovf got=%h want=0", ovf0); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_push();
    idle_inputs();
    qin_v[3] = 1'b1; qin_d[3*W +: W] = 9'h0A5;
    tick();
    idle_inputs();
    total++; if (qout_v0 !== 8'b0000_1000) begin bad++; $display("FAIL single_qout_v got=%b want=00001000", qout_v0); end
    total++; if (dat0(3) !== 9'h0A5) begin bad++; $display("FAIL single_data got=%h want=0a5", dat0(3)); end
    tick();
    total++; if (qout_v0[3] !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", qout_v0[3]); end
  endtask

  task automatic test_full_ovf();
    idle_inputs();
    qout_b[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      qin_v[0] = 1'b1; qin_d[0 +: W] = W'(i); qin_e[0] = (i == 15);
      tick();
    end
    total++; if (cnt0(0) !== CW'(16)) begin bad++; $display("FAIL full_count got=%0d want=16", cnt0(0)); end
    total++; if (qin_b0[0] !== 1'b1) begin bad++; $display("FAIL full_qin_b got=%b want=1", qin_b0[0]); end
    total++; if (ovf0[0] !== 1'b0) begin bad++; $display("FAIL full_ovf_early got=%b want=0", ovf0[0]); end
    qin_d[0 +: W] = 9'h1FF; qin_e[0] = 1'b0;
    tick();
    total++; if (ovf0[0] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf0[0]); end
    total++; if (cnt0(0) !== CW'(16)) begin bad++; $display("FAIL ovf_count got=%0d want=16", cnt0(0)); end
    qin_v[0] = 1'b0; qout_b[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (qout_v0[0] !== 1'b1 || dat0(0) !== W'(i) || qout_e0[0] !== (i == 15))
        begin bad++; $display("FAIL drain_order[%0d] got=%b/%h/%b want=1/%h/%b", i, qout_v0[0], dat0(0), qout_e0[0], W'(i), (i == 15)); end
      tick();
    end
    total++; if (qout_v0[0] !== 1'b0 || ovf0[0] !== 1'b1) begin bad++; $display("FAIL drain_end got=%b ovf=%b want=0 ovf=1", qout_v0[0], ovf0[0]); end
  endtask

  task automatic test_reserve();
    idle_inputs();
    qout_b[1] = 1'b1; qin_v[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin qin_d[1*W +: W] = W'(200 + i); tick(); end
    total++; if (qin_b2[1] !== 1'b0) begin bad++; $display("FAIL reserve_13 got=%b want=0", qin_b2[1]); end
    tick();
    total++; if (qin_b2[1] !== 1'b1 || cnt2(1) !== CW'(14)) begin bad++; $display("FAIL reserve_14 got=%b cnt=%0d want=1 cnt=14", qin_b2[1], cnt2(1)); end
    total++; if (qin_b0[1] !== 1'b0) begin bad++; $display("FAIL reserve0_14 got=%b want=0", qin_b0[1]); end
    repeat (2) tick();
    total++; if (ovf2[1] !== 1'b0 || cnt2(1) !== CW'(16)) begin bad++; $display("FAIL reserve_extra ovf=%b cnt=%0d want ovf=0 cnt=16", ovf2[1], cnt2(1)); end
    idle_inputs(); flush[1] = 1'b1;
    tick();
    flush = '0;
  endtask

  task automatic test_wrap();
    idle_inputs();
    qout_b[2] = 1'b1; qin_v[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin qin_d[2*W +: W] = W'(100 + i); tick(); end
    qout_b[2] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      qin_d[2*W +: W] = W'(116 + k);
      total++; if (dat0(2) !== W'(100 + k) || qout_v0[2] !== 1'b1)
        begin bad++; $display("FAIL wrap_data[%0d] got=%h v=%b want=%h v=1", k, dat0(2), qout_v0[2], W'(100 + k)); end
      tick();
      total++; if (cnt0(2) !== CW'(16) || ovf0[2] !== 1'b0)
        begin bad++; $display("FAIL wrap_count[%0d] got=%0d ovf=%b want=16 ovf=0", k, cnt0(2), ovf0[2]); end
    end
    idle_inputs(); flush[2] = 1'b1;
    tick();
    flush = '0;
  endtask

  task automatic test_flush();
    idle_inputs();
    qout_b[5] = 1'b1; qout_b[4] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      qin_v[5] = 1'b1; qin_d[5*W +: W] = W'(50 + i);
      qin_v[4] = (i < 3); qin_d[4*W +: W] = W'(70 + i);
      tick();
    end
    qin_v = '0; flush[5] = 1'b1; qin_v[5] = 1'b1; qin_d[5*W +: W] = 9'h155;
    tick();
    idle_inputs(); qout_b[4] = 1'b1;
    total++; if (cnt0(5) !== '0 || qout_v0[5] !== 1'b0) begin bad++; $display("FAIL flush_ch5 got cnt=%0d v=%b want 0/0", cnt0(5), qout_v0[5]); end
    total++; if (cnt0(4) !== CW'(3) || dat0(4) !== W'(70)) begin bad++; $display("FAIL flush_ch4 got cnt=%0d d=%h want 3/046", cnt0(4), dat0(4)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        qin_v[c]  = ($urandom_range(0, 3) != 0);
        qout_b[c] = ($urandom_range(0, 9) < ((n / 150) % 2 == 0 ? 7 : 2));
        flush[c]  = ($urandom_range(0, 63) == 0);
        qin_e[c]  = $urandom_range(0, 1);
        qin_d[c*W +: W] = W'($urandom);
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (cnt0(c) !== CW'(mq[c].size()) || cnt2(c) !== CW'(mq[c].size()) ||
            qout_v0[c] !== (mq[c].size() != 0) || ovf0[c] !== movf[c] || ovf2[c] !== movf[c] ||
            qin_b0[c] !== (mq[c].size() >= DEPTH) || qin_b2[c] !== (mq[c].size() >= DEPTH - 2))
          begin bad++; $display("FAIL rand_ctrl n=%0d ch=%0d got cnt=%0d v=%b ovf=%b b=%b/%b want cnt=%0d ovf=%b",
                                n, c, cnt0(c), qout_v0[c], ovf0[c], qin_b0[c], qin_b2[c], mq[c].size(), movf[c]); end
        if (mq[c].size() != 0) begin
          total++;
          if ({dat0(c), qout_e0[c]} !== mq[c][0] || {qout_d2[c*W +: W], qout_e2[c]} !== mq[c][0])
            begin bad++; $display("FAIL rand_head n=%0d ch=%0d got=%h want=%h", n, c, {dat0(c), qout_e0[c]}, mq[c][0]); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    qout_b = '1; qin_v = '1;
    repeat (5) tick();
    idle_inputs(); qout_b = '1;
    #2 reset = 1'b1;
    #1;
    model_clear();
    total++; if (qout_v0 !== '0 || count0 !== '0) begin bad++; $display("FAIL areset_state got v=%h cnt=%h want 0", qout_v0, count0); end
    total++; if (ovf0 !== '0 || qin_b0 !== '0 || qin_b2 !== '0) begin bad++; $display("FAIL areset_flags got ovf=%h b=%h want 0", ovf0, qin_b0); end
    @(negedge clock); reset = 1'b0;
    idle_inputs(); qin_v[0] = 1'b1; qin_d[0 +: W] = 9'h03C;
    tick();
    idle_inputs();
    total++; if (qout_v0[0] !== 1'b1 || dat0(0) !== 9'h03C) begin bad++; $display("FAIL post_reset_push got v=%b d=%h want 1/03c", qout_v0[0], dat0(0)); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_push();
    test_full_ovf();
    test_reserve();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
